imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 177 +++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a one-cycle registered output stage and a skid register.
// Instructions are decoded before storage; in_ready depends only on registered state.
module imm_gen_pipe #(
    parameter int XLEN    = 32,
    parameter bit PC_PASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_type,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc
);

    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_I    = 3'd1;
    localparam logic [2:0] T_S    = 3'd2;
    localparam logic [2:0] T_B    = 3'd3;
    localparam logic [2:0] T_U    = 3'd4;
    localparam logic [2:0] T_J    = 3'd5;
    localparam logic [2:0] T_Z    = 3'd6;
    localparam logic [2:0] T_SH   = 3'd7;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      typ;
        logic            ill;
        logic [XLEN-1:0] pc;
    } entry_t;

    state_t state, state_nx;
    entry_t dec, main_q, skid_q;
    logic   accept, ld_main, ld_skid, mv_skid;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic       is_shift;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    assign opcode   = instr[6:0];
    assign f3       = instr[14:12];
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    always_comb begin
        dec.imm = '0;
        dec.typ = T_NONE;
        dec.ill = 1'b0;
        dec.pc  = PC_PASS ? pc : '0;
        case (opcode)
            7'b0010011: begin
                if (is_shift) begin
                    dec.typ = T_SH;
                    if (XLEN == 64) dec.imm[5:0] = instr[25:20];
                    else            dec.imm[4:0] = instr[24:20];
                end else begin
                    dec.typ = T_I;
                    dec.imm = sext32({{20{instr[31]}}, instr[31:20]});
                end
            end
            7'b0000011, 7'b1100111: begin
                dec.typ = T_I;
                dec.imm = sext32({{20{instr[31]}}, instr[31:20]});
            end
            7'b0100011: begin
                dec.typ = T_S;
                dec.imm = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
            end
            7'b1100011: begin
                dec.typ = T_B;
                dec.imm = sext32({{19{instr[31]}}, instr[31], instr[7],
                                  instr[30:25], instr[11:8], 1'b0});
            end
            7'b0110111, 7'b0010111: begin
                dec.typ = T_U;
                dec.imm = sext32({instr[31:12], 12'b0});
            end
            7'b1101111: begin
                dec.typ = T_J;
                dec.imm = sext32({{11{instr[31]}}, instr[31], instr[19:12],
                                  instr[20], instr[30:21], 1'b0});
            end
            7'b1110011: begin
                if (f3[2]) begin
                    dec.typ      = T_Z;
                    dec.imm[4:0] = instr[19:15];
                end
            end
            7'b0110011, 7'b0001111: ;
            7'b0011011: begin
                if (XLEN != 64) begin
                    dec.ill = 1'b1;
                end else if (is_shift) begin
                    dec.typ      = T_SH;
                    dec.imm[4:0] = instr[24:20];
                end else begin
                    dec.typ = T_I;
                    dec.imm = sext32({{20{instr[31]}}, instr[31:20]});
                end
            end
            7'b0111011: dec.ill = (XLEN != 64);
            default:    dec.ill = 1'b1;
        endcase
    end

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ld_main  = 1'b0;
        ld_skid  = 1'b0;
        mv_skid  = 1'b0;
        if (flush) begin
            state_nx = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    state_nx = ONE;
                    ld_main  = 1'b1;
                end
                ONE: begin
                    if (accept && out_ready) begin
                        ld_main = 1'b1;
                    end else if (accept) begin
                        state_nx = FULL;
                        ld_skid  = 1'b1;
                    end else if (out_ready) begin
                        state_nx = EMPTY;
                    end
                end
                FULL: if (out_ready) begin
                    state_nx = ONE;
                    mv_skid  = 1'b1;
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (ld_main)      main_q <= dec;
            else if (mv_skid) main_q <= skid_q;
            if (ld_skid)      skid_q <= dec;
        end
    end

    assign out_imm     = main_q.imm;
    assign out_type    = main_q.typ;
    assign out_illegal = main_q.ill;
    assign out_pc      = main_q.pc;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode vectors at XLEN=32 and XLEN=64,
// backpressure ordering, flush and asynchronous reset behaviour.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        v32 = 1'b0, flush32 = 1'b0, ordy32 = 1'b0;
    logic [31:0] instr32 = '0, pc32 = '0;
    logic        irdy32, ovld32, oill32;
    logic [31:0] oimm32, opc32;
    logic [2:0]  otyp32;

    logic        v64 = 1'b0, flush64 = 1'b0, ordy64 = 1'b0;
    logic [31:0] instr64 = '0;
    logic [63:0] pc64 = '0;
    logic        irdy64, ovld64, oill64;
    logic [63:0] oimm64, opc64;
    logic [2:0]  otyp64;

    int unsigned passed = 0;
    int unsigned total  = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .PC_PASS(1'b1)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(irdy32),
        .instr(instr32), .pc(pc32), .flush(flush32), .out_valid(ovld32),
        .out_ready(ordy32), .out_imm(oimm32), .out_type(otyp32),
        .out_illegal(oill32), .out_pc(opc32)
    );

    imm_gen_pipe #(.XLEN(64), .PC_PASS(1'b1)) u64 (
        .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(irdy64),
        .instr(instr64), .pc(pc64), .flush(flush64), .out_valid(ovld64),
        .out_ready(ordy64), .out_imm(oimm64), .out_type(otyp64),
        .out_illegal(oill64), .out_pc(opc64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] imm, input logic [2:0] typ,
                         input logic ill);
        chk({tag, "_valid"}, 64'(ovld32), 64'd1);
        chk({tag, "_imm"},   64'(oimm32), 64'(imm));
        chk({tag, "_type"},  64'(otyp32), 64'(typ));
        chk({tag, "_ill"},   64'(oill32), 64'(ill));
    endtask

    task automatic offer32(input logic [31:0] i, input logic [31:0] p);
        v32 = 1'b1; instr32 = i; pc32 = p;
    endtask

    initial begin
        #2;
        chk("rst_valid", 64'(ovld32), 64'd0);
        chk("rst_ready", 64'(irdy32), 64'd1);
        chk("rst_imm",   64'(oimm32), 64'd0);
        chk("rst_type",  64'(otyp32), 64'd0);
        chk("rst_ill",   64'(oill32), 64'd0);
        chk("rst_pc",    64'(opc32),  64'd0);
        #10 rst_n = 1'b1;

        // XLEN=32 decode stream, one instruction per cycle, no backpressure
        ordy32 = 1'b1;
        offer32(32'hFFF00093, 32'h100); step(); chk32("addi", 32'hFFFFFFFF, 3'd1, 1'b0);
        chk("addi_pc", 64'(opc32), 64'h100);
        offer32(32'hFE000EE3, 32'h104); step(); chk32("beq", 32'hFFFFFFFC, 3'd3, 1'b0);
        offer32(32'h300FD073, 32'h108); step(); chk32("csrrwi", 32'h0000001F, 3'd6, 1'b0);
        offer32(32'h00309093, 32'h10C); step(); chk32("slli", 32'h00000003, 3'd7, 1'b0);
        offer32(32'hFE112E23, 32'h110); step(); chk32("sw", 32'hFFFFFFFC, 3'd2, 1'b0);
        offer32(32'h008000EF, 32'h114); step(); chk32("jal", 32'h00000008, 3'd5, 1'b0);
        offer32(32'h80000037, 32'h118); step(); chk32("lui", 32'h80000000, 3'd4, 1'b0);
        offer32(32'h00000033, 32'h11C); step(); chk32("add", 32'h0, 3'd0, 1'b0);
        offer32(32'h0000001B, 32'h120); step(); chk32("addiw32", 32'h0, 3'd0, 1'b1);
        offer32(32'h0000007F, 32'h124); step(); chk32("ill7f", 32'h0, 3'd0, 1'b1);
        chk("ill7f_pc", 64'(opc32), 64'h124);
        v32 = 1'b0; step();
        chk("drain_valid", 64'(ovld32), 64'd0);

        // Backpressure: A and B stored, C held upstream
        ordy32 = 1'b0;
        offer32(32'h00100013, 32'h200); step();
        chk32("stA", 32'd1, 3'd1, 1'b0);
        chk("stA_rdy", 64'(irdy32), 64'd1);
        offer32(32'h00200013, 32'h204); step();
        chk("stB_rdy", 64'(irdy32), 64'd0);
        chk("stB_imm", 64'(oimm32), 64'd1);
        offer32(32'h00300013, 32'h208); step();
        chk("stC_rdy", 64'(irdy32), 64'd0);
        step();
        chk32("stall_A", 32'd1, 3'd1, 1'b0);
        chk("stall_pc", 64'(opc32), 64'h200);
        ordy32 = 1'b1; step();
        chk32("outB", 32'd2, 3'd1, 1'b0);
        chk("outB_pc", 64'(opc32), 64'h204);
        chk("outB_rdy", 64'(irdy32), 64'd1);
        step();
        chk32("outC", 32'd3, 3'd1, 1'b0);
        chk("outC_pc", 64'(opc32), 64'h208);
        v32 = 1'b0; step();
        chk("ord_empty", 64'(ovld32), 64'd0);

        // Flush while FULL, with another instruction offered in the flush cycle
        ordy32 = 1'b0;
        offer32(32'h00400013, 32'h300); step();
        offer32(32'h00500013, 32'h304); step();
        chk("fl_full", 64'(irdy32), 64'd0);
        offer32(32'h00600013, 32'h308); flush32 = 1'b1;
        chk("fl_rdy_during", 64'(irdy32), 64'd0);
        step();
        flush32 = 1'b0; v32 = 1'b0;
        chk("fl_valid", 64'(ovld32), 64'd0);
        chk("fl_rdy", 64'(irdy32), 64'd1);
        ordy32 = 1'b1; step();
        chk("fl_after", 64'(ovld32), 64'd0);

        // Asynchronous reset while ONE
        ordy32 = 1'b0;
        offer32(32'h00700013, 32'h400); step();
        chk("ar_one", 64'(ovld32), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(ovld32), 64'd0);
        chk("ar_imm",   64'(oimm32), 64'd0);
        chk("ar_type",  64'(otyp32), 64'd0);
        chk("ar_pc",    64'(opc32),  64'd0);
        chk("ar_rdy",   64'(irdy32), 64'd1);
        #3 rst_n = 1'b1;
        ordy32 = 1'b1;
        offer32(32'h00800013, 32'h404); step();
        chk32("ar_next", 32'd8, 3'd1, 1'b0);
        chk("ar_next_pc", 64'(opc32), 64'h404);
        v32 = 1'b0;

        // XLEN=64 instance
        ordy64 = 1'b1; v64 = 1'b1;
        instr64 = 32'h80000037; pc64 = 64'h1_0000_0004; step();
        chk("x64_lui_imm",  oimm64, 64'hFFFFFFFF80000000);
        chk("x64_lui_type", 64'(otyp64), 64'd4);
        chk("x64_lui_pc",   opc64, 64'h1_0000_0004);
        instr64 = 32'h0000007F; step();
        chk("x64_ill",      64'(oill64), 64'd1);
        chk("x64_ill_imm",  oimm64, 64'd0);
        chk("x64_ill_type", 64'(otyp64), 64'd0);
        instr64 = 32'h03F01013; step();
        chk("x64_slli_imm",  oimm64, 64'd63);
        chk("x64_slli_type", 64'(otyp64), 64'd7);
        instr64 = 32'hFFF0001B; step();
        chk("x64_addiw_imm", oimm64, 64'hFFFFFFFFFFFFFFFF);
        chk("x64_addiw_ill", 64'(oill64), 64'd0);
        instr64 = 32'h0000003B; step();
        chk("x64_addw_ill",  64'(oill64), 64'd0);
        chk("x64_addw_type", 64'(otyp64), 64'd0);
        v64 = 1'b0; step();
        chk("x64_empty", 64'(ovld64), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
